reg_rr_write_arbiter: RTL

- Shares one DATA_WIDTH-bit storage register among NUM_REQ requesters.
- Each requester presents a request and a data word. A round-robin scheduler picks one winner per write slot, loads its word into the register and returns a one-cycle grant pulse.
- An optional lock-out gap after each write gives requesters time to drop their request.
- Sits between producer blocks and any consumer of the shared register value.

---
 rtl/reg_rr_write_arbiter.sv | 92 +++++++++
 1 files changed

// File: rtl/reg_rr_write_arbiter.sv
// reg_rr_write_arbiter: round-robin arbitration of many writers onto one shared register with an optional lock-out gap
module reg_rr_write_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_WIDTH = 4,
  parameter int RESET_VAL = 0,
  parameter int GAP = 1
) (
  input  logic                          C,
  input  logic                          R,
  input  logic [NUM_REQ-1:0]            REQ,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] D,
  output logic [NUM_REQ-1:0]            GNT,
  output logic [DATA_WIDTH-1:0]         Q,
  output logic [$clog2(NUM_REQ)-1:0]    LAST_ID,
  output logic                          VALID,
  output logic                          BUSY
);
  localparam int IW = $clog2(NUM_REQ);
  typedef enum logic {ST_IDLE, ST_GAP} state_t;
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [IW-1:0] ptr, ptr_n, win, last_n;
  logic [NUM_REQ-1:0] gnt_n;
  logic [DATA_WIDTH-1:0] q_n, win_data;
  logic valid_n, busy_n, found;
  int idx;
  // first requesting index at or above ptr, wrapping; only the winner's slice is routed to Q
  always_comb begin
    win = ptr;
    win_data = Q;
    found = 1'b0;
    idx = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      idx = idx >= NUM_REQ ? idx - NUM_REQ : idx;
      if (!found && REQ[IW'(idx)]) begin
        win = IW'(idx);
        win_data = D[idx*DATA_WIDTH +: DATA_WIDTH];
        found = 1'b1;
      end
    end
  end
  // next state: write the winner when idle, count down the lock-out gap otherwise
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    ptr_n = ptr;
    q_n = Q;
    gnt_n = '0;
    last_n = LAST_ID;
    valid_n = VALID;
    busy_n = BUSY;
    if (state == ST_GAP) begin
      cnt_n = cnt - 4'd1;
      state_n = cnt == 4'd1 ? ST_IDLE : ST_GAP;
      busy_n = cnt != 4'd1;
    end else if (|REQ) begin
      q_n = win_data;
      gnt_n = NUM_REQ'(1) << win;
      last_n = win;
      valid_n = 1'b1;
      ptr_n = int'(win) == NUM_REQ - 1 ? '0 : win + IW'(1);
      if (GAP > 0) begin
        cnt_n = 4'(GAP);
        busy_n = 1'b1;
        state_n = ST_GAP;
      end
    end
  end
  // state and output registers, cleared asynchronously
  always_ff @(posedge C or posedge R) begin
    if (R) begin
      state <= ST_IDLE;
      cnt <= '0;
      ptr <= '0;
      Q <= DATA_WIDTH'(RESET_VAL);
      GNT <= '0;
      LAST_ID <= '0;
      VALID <= 1'b0;
      BUSY <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      ptr <= ptr_n;
      Q <= q_n;
      GNT <= gnt_n;
      LAST_ID <= last_n;
      VALID <= valid_n;
      BUSY <= busy_n;
    end
  end
endmodule
